alu_operand_sequencer: RTL

- Multi-cycle driver for the core's 4-bit ALU. It is the requester side of the ALU's op/temp_a/temp_b -> out/carry/zero interface.
- Fetches operand A from nibble memory, and operand B from memory or an immediate.
- Presents the operands to the ALU, writes the result back to A's address, and owns the carry and zero flags.
- Sits between the instruction decoder and the memory/ALU datapath.

---
 rtl/alu_operand_sequencer_pkg.sv | 37 +++
 rtl/alu_operand_sequencer_if.sv | 35 +++
 rtl/alu_operand_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types for the operand sequencer: ALU operation codes, sequencer
// states and the helper that says which operations update the carry flag.
package alu_operand_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_ADC,
    ALU_ADC_NO_DEC,
    ALU_SUB,
    ALU_SBC,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOT,
    ALU_RRC,
    ALU_RLC,
    ALU_CP
  } alu_op;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    EXEC,
    DONE
  } seq_state_t;

  // Logic ops leave C alone so multi-nibble carry chains survive masking steps.
  function automatic logic alu_op_affects_carry(alu_op op);
    case (op)
      ALU_ADD, ALU_ADC, ALU_ADC_NO_DEC, ALU_SUB, ALU_SBC,
      ALU_RRC, ALU_RLC, ALU_CP: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Memory and ALU datapath bus between the operand sequencer (master) and the
// nibble memory / core ALU (slave).
interface alu_operand_sequencer_if #(
  parameter int ADDR_WIDTH = 12
);
  import alu_operand_sequencer_pkg::*;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read_en;
  logic [3:0]            mem_read_data;
  logic                  mem_write_en;
  logic [3:0]            mem_write_data;

  alu_op                 alu_op_out;
  logic [3:0]            alu_temp_a;
  logic [3:0]            alu_temp_b;
  logic                  alu_carry_in;
  logic                  alu_decimal_in;
  logic [3:0]            alu_out;
  logic                  alu_carry;
  logic                  alu_zero;

  modport master (
    output mem_addr, mem_read_en, mem_write_en, mem_write_data,
    output alu_op_out, alu_temp_a, alu_temp_b, alu_carry_in, alu_decimal_in,
    input  mem_read_data, alu_out, alu_carry, alu_zero
  );

  modport slave (
    input  mem_addr, mem_read_en, mem_write_en, mem_write_data,
    input  alu_op_out, alu_temp_a, alu_temp_b, alu_carry_in, alu_decimal_in,
    output mem_read_data, alu_out, alu_carry, alu_zero
  );

endinterface

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle driver for the 4-bit ALU: fetches A (and B from memory or an
// immediate), runs the op, writes the result back to A and owns the C/Z flags.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  // Request handshake: start is taken only while busy is low, and the req_*
  // fields must be valid in that same cycle; done pulses once after commit.
  input  logic                  start,
  input  alu_op                 req_op,
  input  logic [ADDR_WIDTH-1:0] req_a_addr,
  input  logic                  req_b_is_mem,
  input  logic [ADDR_WIDTH-1:0] req_b_addr,
  input  logic [3:0]            req_imm,
  input  logic                  req_write_back,
  input  logic                  decimal_flag,
  output logic                  busy,
  output logic                  done,
  output logic                  flag_carry,
  output logic                  flag_zero,
  output seq_state_t            dbg_state,
  alu_operand_sequencer_if.master bus
);

  seq_state_t            state;
  seq_state_t            state_next;

  alu_op                 op_q;
  logic [ADDR_WIDTH-1:0] a_addr_q;
  logic                  b_is_mem_q;
  logic [ADDR_WIDTH-1:0] b_addr_q;
  logic [3:0]            imm_q;
  logic                  write_back_q;
  logic [3:0]            temp_a;
  logic [3:0]            temp_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next         = state;
    bus.mem_addr       = a_addr_q;
    bus.mem_read_en    = 1'b0;
    bus.mem_write_en   = 1'b0;
    bus.mem_write_data = 4'h0;
    case (state)
      IDLE: begin
        if (start) begin
          bus.mem_addr    = req_a_addr;
          bus.mem_read_en = 1'b1;
          state_next      = FETCH_A;
        end
      end
      FETCH_A: begin
        if (b_is_mem_q) begin
          bus.mem_addr    = b_addr_q;
          bus.mem_read_en = 1'b1;
          state_next      = FETCH_B;
        end else begin
          state_next = EXEC;
        end
      end
      FETCH_B: state_next = EXEC;
      EXEC: begin
        // CP only sets flags; its difference is never stored.
        if (write_back_q && (op_q != ALU_CP)) begin
          bus.mem_write_en   = 1'b1;
          bus.mem_write_data = bus.alu_out;
        end
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= ALU_ADD;
      a_addr_q     <= '0;
      b_is_mem_q   <= 1'b0;
      b_addr_q     <= '0;
      imm_q        <= 4'h0;
      write_back_q <= 1'b0;
      temp_a       <= 4'h0;
      temp_b       <= 4'h0;
      flag_carry   <= 1'b0;
      flag_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q         <= req_op;
            a_addr_q     <= req_a_addr;
            b_is_mem_q   <= req_b_is_mem;
            b_addr_q     <= req_b_addr;
            imm_q        <= req_imm;
            write_back_q <= req_write_back;
          end
        end
        FETCH_A: begin
          temp_a <= bus.mem_read_data;
          if (!b_is_mem_q) temp_b <= imm_q;
        end
        FETCH_B: temp_b <= bus.mem_read_data;
        EXEC: begin
          flag_zero <= bus.alu_zero;
          if (alu_op_affects_carry(op_q)) flag_carry <= bus.alu_carry;
        end
        default: ;
      endcase
    end
  end

  // The ALU sees the registered C, so carry-consuming ops use the pre-op flag.
  assign bus.alu_op_out     = op_q;
  assign bus.alu_temp_a     = temp_a;
  assign bus.alu_temp_b     = temp_b;
  assign bus.alu_carry_in   = flag_carry;
  assign bus.alu_decimal_in = decimal_flag;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule
